// File: rtl/ysyx_25030085_lsu.sv
// Load/store unit: one outstanding valid/ready data-memory transaction with load formatting.
// Optional watchdog enabled by defining LSU_TIMEOUT_EN (limit TIMEOUT_CYC cycles in REQ/WAIT).
module ysyx_25030085_lsu #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        req_bad;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic        timeout_hit;

  assign req_ready = (state == IDLE) && !rst;

  // Reject illegal encodings and misaligned halves/words before touching memory.
  always_comb begin
    req_bad = 1'b0;
    if (req_wen) begin
      if (req_funct3[2]) req_bad = 1'b1;
    end else if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) begin
      req_bad = 1'b1;
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_bad = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_bad = 1'b1;
  end

  always_comb begin
    st_data = req_wdata;
    st_mask = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        st_data = {4{req_wdata[7:0]}};
        st_mask = 4'(4'b0001 << req_addr[1:0]);
      end
      2'b01: begin
        st_data = {2{req_wdata[15:0]}};
        st_mask = 4'(4'b0011 << req_addr[1:0]);
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b010:  return rdata;
      3'b100:  return {24'b0, sh[7:0]};
      3'b101:  return {16'b0, sh[15:0]};
      default: return 32'b0;
    endcase
  endfunction

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt;

  // Held at zero in IDLE so it starts from zero on entry to REQ and keeps counting through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == REQ || state == WAIT) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      funct3_q   <= 3'b0;
      off_q      <= 2'b0;
      mem_valid  <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'b0;
      mem_wmask  <= 4'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            if (req_bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'b0;
            end else begin
              state     <= REQ;
              mem_valid <= 1'b1;
              mem_wen   <= req_wen;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= st_data;
              mem_wmask <= req_wen ? st_mask : 4'b0000;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wen   <= 1'b0;
            mem_wmask <= 4'b0;
            if (mem_wen) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= 32'b0;
            end else begin
              state <= WAIT;
            end
          end else if (timeout_hit) begin
            mem_valid  <= 1'b0;
            mem_wen    <= 1'b0;
            mem_wmask  <= 4'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'b0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_fmt(funct3_q, off_q, mem_rdata);
          end else if (timeout_hit) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'b0;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// Scoreboard bench for ysyx_25030085_lsu: expected responses are queued at issue and
// checked when resp_valid pulses; latency and mem_* stability are checked per cycle.
module tb_ysyx_25030085_lsu;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  resp_t expQ[$];
  int    testsRun    = 0;
  int    testsFailed = 0;

  ysyx_25030085_lsu #(.ADDR_W(32), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    resp_t e;
    if (resp_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("resp_err", 32'(resp_err), 32'(e.err));
        checkOutput("resp_rdata", resp_rdata, e.data);
      end
    end
  end

  task automatic applyStimulus(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rword,
                               input int stall, input bit giveRvalid);
    logic [1:0]  off;
    logic [7:0]  b;
    logic [15:0] h;
    logic        expErr;
    logic [31:0] expData, expWdata;
    logic [3:0]  expMask;
    int          expLat, cycles;
    bit          done;
    resp_t       e;

    off      = addr[1:0];
    b        = rword[8*off +: 8];
    h        = off[1] ? rword[31:16] : rword[15:0];
    expData  = 32'b0;
    expWdata = wdata;
    expMask  = 4'b1111;
    expErr   = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    if (wen) expErr = expErr || f3[2];
    else     expErr = expErr || f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
    if (wen) begin
      case (f3[1:0])
        2'b00:   begin expWdata = {4{wdata[7:0]}};  expMask = 4'(4'b0001 << off); end
        2'b01:   begin expWdata = {2{wdata[15:0]}}; expMask = 4'(4'b0011 << off); end
        default: ;
      endcase
    end else begin
      case (f3)
        3'b000:  expData = {{24{b[7]}}, b};
        3'b001:  expData = {{16{h[15]}}, h};
        3'b010:  expData = rword;
        3'b100:  expData = {24'b0, b};
        3'b101:  expData = {16'b0, h};
        default: expData = 32'b0;
      endcase
    end
    if (expErr)      expLat = 1;
    else if (wen)    expLat = 2 + stall;
    else             expLat = 3 + stall;
    if (!expErr && !wen && !giveRvalid) begin
      expErr = 1'b1;
      expLat = TIMEOUT + 1;
    end
    if (expErr || wen) expData = 32'b0;
    e.err = expErr;
    e.data = expData;
    expQ.push_back(e);

    @(negedge clk);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    mem_ready  = (stall == 0);
    mem_rvalid = giveRvalid;
    mem_rdata  = rword;
    @(posedge clk);
    #1 req_valid = 1'b0;

    cycles = 0;
    done   = 0;
    while (!done && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (mem_valid) begin
        if (expErr && expLat == 1) begin
          checkOutput("no_mem_access", 32'd1, 32'd0);
        end else begin
          checkOutput("mem_addr", mem_addr, {addr[31:2], 2'b00});
          checkOutput("mem_wen", 32'(mem_wen), 32'(wen));
          checkOutput("mem_wmask", 32'(mem_wmask), wen ? 32'(expMask) : 32'd0);
          if (wen) checkOutput("mem_wdata", mem_wdata, expWdata);
        end
      end
      if (resp_valid) begin
        checkOutput("latency", 32'(cycles), 32'(expLat));
        done = 1;
      end
      if (stall > 0 && cycles == stall + 1) mem_ready = 1'b1;
    end
    if (!done) checkOutput("resp_wait_bound", 32'd0, 32'd1);
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("resp_pulse_one_cycle", 32'(resp_valid), 32'd0);
    checkOutput("mem_valid_idle", 32'(mem_valid), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = 32'b0;
    req_wdata  = 32'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;

    applyStimulus(1'b0, 3'b010, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 0, 1'b1);
    applyStimulus(1'b0, 3'b000, 32'h8000_0003, 32'h0,         32'h8011_2233, 0, 1'b1);
    applyStimulus(1'b0, 3'b100, 32'h8000_0003, 32'h0,         32'h8011_2233, 0, 1'b1);
    applyStimulus(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h0,         0, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h8000_0002, 32'h0,         32'h1111_1111, 0, 1'b1);
    applyStimulus(1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'h0,         5, 1'b0);
    applyStimulus(1'b0, 3'b001, 32'h8000_0002, 32'h0,         32'h8001_7FFF, 0, 1'b1);
    applyStimulus(1'b0, 3'b101, 32'h8000_0002, 32'h0,         32'h8001_7FFF, 0, 1'b1);
    applyStimulus(1'b0, 3'b001, 32'h8000_0000, 32'h0,         32'h8001_7FFF, 3, 1'b1);
    applyStimulus(1'b1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'h0,         0, 1'b0);
    applyStimulus(1'b0, 3'b000, 32'h8000_0000, 32'h0,         32'h1234_567F, 0, 1'b1);
    applyStimulus(1'b0, 3'b011, 32'h8000_0000, 32'h0,         32'h0,         0, 1'b1);
    applyStimulus(1'b1, 3'b100, 32'h8000_0000, 32'h5555_5555, 32'h0,         0, 1'b0);
    applyStimulus(1'b0, 3'b101, 32'h8000_0001, 32'h0,         32'h0,         0, 1'b1);
    applyStimulus(1'b1, 3'b000, 32'h8000_0003, 32'h0000_003C, 32'h0,         2, 1'b0);

    // Reset while in WAIT: no response may appear, even with a late mem_rvalid.
    @(negedge clk);
    req_valid  = 1'b1;
    req_wen    = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h8000_0010;
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0BAD_0BAD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("wait_test_mem_valid", 32'(mem_valid), 32'd1);
    @(negedge clk);
    rst        = 1'b1;
    mem_rvalid = 1'b1;
    @(negedge clk);
    checkOutput("rst_wait_mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("rst_wait_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_wait_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);
    end
    mem_rvalid = 1'b0;

    applyStimulus(1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'h0123_4567, 0, 1'b1);

`ifdef LSU_TIMEOUT_EN
    applyStimulus(1'b0, 3'b010, 32'h8000_0024, 32'h0, 32'h0, 0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
